uart_byte_fifo: RTL

- Byte buffer and transmit sequencer between uart_rx and uart_tx in the UART top level.
- Absorbs single-cycle received-byte strobes into a circular FIFO and drains them one at a time into uart_tx using the transmitter's busy/done handshake.
- Replaces the direct data_avail interconnect so back-to-back received bytes are not lost while the transmitter is occupied.
- Sticky overflow and timeout flags for debug LEDs.

---
 rtl/uart_byte_fifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between uart_rx and uart_tx: buffers receive strobes and launches
// bytes one at a time into the transmitter using its busy/done handshake.
module uart_byte_fifo #(
    parameter int DEPTH        = 16,
    parameter int TIMEOUT_CLKS = 9548
) (
    input  logic                     clk_50M,
    input  logic                     rst,
    input  logic [7:0]               i_rx_byte,
    input  logic                     i_rx_avail,
    input  logic                     i_tx_busy,
    input  logic                     i_tx_done,
    output logic [7:0]               o_tx_byte,
    output logic                     o_tx_avail,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_overflow,
    output logic                     o_tx_timeout,
    output logic                     dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count_nxt;
    logic [7:0]     tx_byte_q;
    logic [TW-1:0]  timer, timer_nxt;
    logic           launch, timeout_set, push_ok, push_drop;

    // Handshake: i_rx_avail is a fire-and-forget strobe (no ready; a push into a
    // full FIFO is dropped and flagged). A launch is o_tx_avail for one cycle,
    // only when uart_tx is not busy; the frame is closed by i_tx_done or timeout.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        launch      = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (!o_empty && !i_tx_busy) begin
                    launch    = 1'b1;
                    timer_nxt = '0;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
                    state_nxt = IDLE;
                end else if (timer == TW'(TIMEOUT_CLKS - 1)) begin
                    timeout_set = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A launch in the same cycle frees a slot, so a push into a full FIFO is legal then.
    assign push_ok   = i_rx_avail && (!o_full || launch);
    assign push_drop = i_rx_avail && o_full && !launch;

    always_comb begin
        count_nxt = o_count;
        case ({push_ok, launch})
            2'b10:   count_nxt = o_count + CW'(1);
            2'b01:   count_nxt = o_count - CW'(1);
            default: count_nxt = o_count;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_count      <= '0;
            o_empty      <= 1'b1;
            o_full       <= 1'b0;
            tx_byte_q    <= 8'h00;
            o_overflow   <= 1'b0;
            o_tx_timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            o_count <= count_nxt;
            o_empty <= (count_nxt == '0);
            o_full  <= (count_nxt == CW'(DEPTH));
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (launch) begin
                rd_ptr    <= rd_ptr + AW'(1);
                tx_byte_q <= mem[rd_ptr];
            end
            if (push_drop)   o_overflow   <= 1'b1;
            if (timeout_set) o_tx_timeout <= 1'b1;
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk_50M) begin
        if (push_ok) mem[wr_ptr] <= i_rx_byte;
    end

    // The launched byte appears in the launch cycle itself and is then held.
    assign o_tx_byte  = launch ? mem[rd_ptr] : tx_byte_q;
    assign o_tx_avail = launch;
    assign dbg_state  = state;

endmodule
